// File: rtl/ps2_keystate_decoder.sv
`default_nettype none
// ps2_keystate_decoder: PS/2 set-2 receiver that tracks live make/break state of every key.
// rev 1.0
module ps2_keystate_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [127:0] keys,
  output logic [127:0] e_keys,
  output logic [7:0]   scan_code,
  output logic         scan_valid,
  output logic         frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  localparam logic [1:0] D_IDLE    = 2'd0;
  localparam logic [1:0] D_EXT     = 2'd1;
  localparam logic [1:0] D_BRK     = 2'd2;
  localparam logic [1:0] D_EXT_BRK = 2'd3;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall, r_fall_data;
  logic [1:0]    r_rx_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic [1:0]    r_d_state;
  logic [6:0]    w_code_lo;
  logic          w_code_low;

  // Lines idle high, so the synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_filt  <= 1'b1;
      r_filt_cnt  <= '0;
      r_fall      <= 1'b0;
      r_fall_data <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt  <= r_clk_s2;
        r_filt_cnt  <= '0;
        r_fall      <= ~r_clk_s2;
        r_fall_data <= r_dat_s2;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_to_cnt   <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (r_rx_state == RX_IDLE || r_fall)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;

      if (r_rx_state != RX_IDLE && !r_fall && r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err  <= 1'b1;
        r_rx_state <= RX_IDLE;
      end else if (r_fall) begin
        case (r_rx_state)
          RX_IDLE: begin
            if (!r_fall_data) begin
              r_rx_state <= RX_DATA;
              r_bit_cnt  <= '0;
            end
          end
          RX_DATA: begin
            // LSB arrives first, so shift in from the top.
            r_shift   <= {r_fall_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7)
              r_rx_state <= RX_PARITY;
          end
          RX_PARITY: begin
            r_parity   <= r_fall_data;
            r_rx_state <= RX_STOP;
          end
          default: begin
            if (r_fall_data && (^{r_shift, r_parity})) begin
              scan_code  <= r_shift;
              scan_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            r_rx_state <= RX_IDLE;
          end
        endcase
      end
    end
  end

  assign w_code_lo  = scan_code[6:0];
  assign w_code_low = ~scan_code[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_state <= D_IDLE;
      keys      <= '0;
      e_keys    <= '0;
    end else if (scan_valid) begin
      case (r_d_state)
        D_IDLE: begin
          if (scan_code == 8'hE0)
            r_d_state <= D_EXT;
          else if (scan_code == 8'hF0)
            r_d_state <= D_BRK;
          else if (w_code_low)
            keys[w_code_lo] <= 1'b1;
        end
        D_EXT: begin
          if (scan_code == 8'hF0) begin
            r_d_state <= D_EXT_BRK;
          end else begin
            if (w_code_low)
              e_keys[w_code_lo] <= 1'b1;
            r_d_state <= D_IDLE;
          end
        end
        D_BRK: begin
          if (w_code_low)
            keys[w_code_lo] <= 1'b0;
          r_d_state <= D_IDLE;
        end
        default: begin
          if (w_code_low)
            e_keys[w_code_lo] <= 1'b0;
          r_d_state <= D_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keystate_decoder.sv
`default_nettype none
// tb_ps2_keystate_decoder: directed PS/2 frames with a scoreboard of expected scan events.
module tb_ps2_keystate_decoder;

  localparam int TO_CYC = 2000;

  localparam int OP_NONE = 0;
  localparam int OP_SETK = 1;
  localparam int OP_CLRK = 2;
  localparam int OP_SETE = 3;
  localparam int OP_CLRE = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [127:0] keys, e_keys;
  logic [7:0]   scan_code;
  logic         scan_valid, frame_err;

  ps2_keystate_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keys(keys), .e_keys(e_keys), .scan_code(scan_code),
    .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         err;
    logic [7:0]   code;
    logic [127:0] kb, ekb;
    logic [127:0] k, ek;
  } exp_t;

  exp_t         q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [127:0] exp_k = '0;
  logic [127:0] exp_ek = '0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_bits(logic [7:0] code, logic bad_par);
    logic par;
    par = ~(^code) ^ bad_par;
    return {1'b1, par, code, 1'b0};
  endfunction

  task automatic send(input logic [7:0] code, input int op);
    exp_t e;
    e.err = 1'b0; e.code = code; e.kb = exp_k; e.ekb = exp_ek;
    case (op)
      OP_SETK: exp_k[code[6:0]] = 1'b1;
      OP_CLRK: exp_k[code[6:0]] = 1'b0;
      OP_SETE: exp_ek[code[6:0]] = 1'b1;
      OP_CLRE: exp_ek[code[6:0]] = 1'b0;
      default: ;
    endcase
    e.k = exp_k; e.ek = exp_ek;
    q.push_back(e);
    send_bits(frame_bits(code, 1'b0), 11);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.code = 8'h00; e.kb = exp_k; e.ekb = exp_ek;
    e.k = exp_k; e.ek = exp_ek;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d events still pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: every scan_valid/frame_err pulse consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scan_valid || frame_err) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: valid=%0b err=%0b code=%h, required no event",
                   scan_valid, frame_err, scan_code);
        end else begin
          e = q.pop_front();
          chk("event_kind", {126'd0, frame_err, scan_valid}, {126'd0, e.err, ~e.err});
          if (!e.err) begin
            chk("scan_code", 128'(scan_code), 128'(e.code));
            chk("keys_pre", keys, e.kb);
            chk("e_keys_pre", e_keys, e.ekb);
            @(negedge clk);
          end
          chk("keys", keys, e.k);
          chk("e_keys", e_keys, e.ek);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_keys", keys, '0);
    chk("reset_e_keys", e_keys, '0);
    chk("reset_outs", {118'd0, scan_code, scan_valid, frame_err}, '0);

    send(8'h1C, OP_SETK);
    send(8'h24, OP_SETK);
    send(8'hF0, OP_NONE);
    send(8'h1C, OP_CLRK);

    send(8'hE0, OP_NONE);
    send(8'h75, OP_SETE);
    send(8'hE0, OP_NONE);
    send(8'hF0, OP_NONE);
    send(8'h75, OP_CLRE);

    push_err();
    send_bits(frame_bits(8'h1C, 1'b1), 11);
    send(8'h29, OP_SETK);

    push_err();
    send_bits(frame_bits(8'h55, 1'b0), 5);
    repeat (TO_CYC + 500) @(negedge clk);
    send(8'h1C, OP_SETK);
    send(8'h1C, OP_SETK);

    send(8'hAA, OP_NONE);
    send(8'hE1, OP_NONE);
    send(8'h14, OP_SETK);
    send(8'h77, OP_SETK);
    send(8'hE1, OP_NONE);
    send(8'hF0, OP_NONE);
    send(8'h14, OP_CLRK);
    send(8'hF0, OP_NONE);
    send(8'h77, OP_CLRK);

    send(8'hF0, OP_NONE);
    drain();
    send_bits(frame_bits(8'h1C, 1'b0), 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_k  = '0;
    exp_ek = '0;
    @(negedge clk);
    chk("midreset_keys", keys, '0);
    chk("midreset_e_keys", e_keys, '0);
    repeat (50) @(negedge clk);
    send(8'h1C, OP_SETK);

    drain();
    chk("final_scan_code", 128'(scan_code), 128'h1C);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
